// File: rtl/isim_pkg.sv
// Shared definitions for the ISim self-running simulation top.
//  - state_t      : run FSM encoding (IDLE/RUN/DONE, 2 bits, value 3 unused)
//  - LFSR_SEED_DEFAULT : default non-zero LFSR reset value
//  - LFSR_TAP_*   : feedback tap bit positions for x^16+x^14+x^13+x^11+1
//  - lfsr16_step  : one Fibonacci shift of the 16-bit LFSR
package isim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Polynomial exponents 16,14,13,11 map to state bits 15,13,12,10.
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] l);
        logic fb;
        fb = l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D];
        return {l[14:0], fb};
    endfunction

endpackage

// File: rtl/isim_top_level_lfsr16.sv
// 16-bit Fibonacci LFSR that steps on every clock.
// Ports:
//  clk   in  1   rising-edge clock
//  reset in  1   asynchronous active-high reset, loads SEED
//  q     out 16  current LFSR state
module lfsr16
    import isim_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = lfsr16_step(lfsr_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/isim_top_level.sv
// Self-contained simulation top: free-running counter, 16-bit LFSR,
// heartbeat toggle and a one-shot run FSM that sums LFSR values for a
// fixed window and then stays in DONE until reset.
// Ports:
//  clk       in  1      rising-edge clock
//  reset     in  1      asynchronous active-high reset
//  count     out CNT_W  free-running cycle counter
//  lfsr      out 16     LFSR state
//  heartbeat out 1      toggles every HB_DIV clocks
//  state     out 2      0 IDLE, 1 RUN, 2 DONE
//  checksum  out 16     wrap-around sum of LFSR values seen in RUN
//  done      out 1      high while in DONE
module isim_top_level
    import isim_pkg::*;
#(
    parameter int          CNT_W      = 8,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT,
    parameter int          HB_DIV     = 4,
    parameter int          RUN_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      lfsr,
    output logic             heartbeat,
    output logic [1:0]       state,
    output logic [15:0]      checksum,
    output logic             done
);

    localparam int HB_W = $clog2(HB_DIV + 1);
    localparam int RC_W = $clog2(RUN_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_LAST  = HB_W'(HB_DIV - 1);
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [HB_W-1:0]  hb_cnt_reg;
    logic             heartbeat_reg;
    logic [15:0]      lfsr_q;

    state_t           state_reg;
    state_t           state_next;
    logic [RC_W-1:0]  run_cnt_reg;
    logic [RC_W-1:0]  run_cnt_next;
    logic [15:0]      checksum_reg;
    logic [15:0]      checksum_next;
    logic             done_reg;
    logic             done_next;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Counter and heartbeat run independently of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= '0;
            hb_cnt_reg    <= '0;
            heartbeat_reg <= 1'b0;
        end else begin
            count_reg <= count_reg + 1'b1;
            if (hb_cnt_reg == HB_LAST) begin
                hb_cnt_reg    <= '0;
                heartbeat_reg <= ~heartbeat_reg;
            end else begin
                hb_cnt_reg <= hb_cnt_reg + 1'b1;
            end
        end
    end

    // FSM state register (also holds the FSM-owned datapath registers).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            run_cnt_reg  <= '0;
            checksum_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            run_cnt_reg  <= run_cnt_next;
            checksum_reg <= checksum_next;
            done_reg     <= done_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN: begin
                if (run_cnt_reg == RUN_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. done is registered from state_next so it tracks
    // state==DONE on the same edge with no extra latency.
    always_comb begin
        run_cnt_next  = run_cnt_reg;
        checksum_next = checksum_reg;
        done_next     = (state_next == ST_DONE);
        if (state_reg == ST_RUN) begin
            // Accumulate the pre-step LFSR value; the final RUN cycle
            // still contributes before moving to DONE.
            checksum_next = checksum_reg + lfsr_q;
            run_cnt_next  = run_cnt_reg + 1'b1;
        end
    end

    assign count     = count_reg;
    assign lfsr      = lfsr_q;
    assign heartbeat = heartbeat_reg;
    assign state     = state_reg;
    assign checksum  = checksum_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_isim_top_level.sv
// Bench for isim_top_level: a cycle-indexed behavioural model checked on
// every falling edge, plus directed literal checks at fixed points.
module tb_isim_top_level;

    logic        clk;
    logic        reset;
    logic [7:0]  count;
    logic [15:0] lfsr;
    logic        heartbeat;
    logic [1:0]  state;
    logic [15:0] checksum;
    logic        done;

    int checks = 0;
    int errors = 0;
    int n      = 0;     // rising edges since reset release
    bit check_en = 1'b0;

    isim_top_level dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .lfsr      (lfsr),
        .heartbeat (heartbeat),
        .state     (state),
        .checksum  (checksum),
        .done      (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // LFSR value k steps after the seed, from the polynomial's exponents.
    function automatic logic [15:0] model_lfsr(input int k);
        int exps [4] = '{16, 14, 13, 11};
        logic [15:0] v;
        logic fb;
        v = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            fb = 1'b0;
            for (int e = 0; e < 4; e++) fb = fb ^ v[exps[e] - 1];
            v = {v[14:0], fb};
        end
        return v;
    endfunction

    // Sum of LFSR values observed during RUN edges 2..min(k,17).
    function automatic logic [15:0] model_checksum(input int k);
        int last;
        int sum;
        last = (k < 17) ? k : 17;
        sum = 0;
        for (int j = 1; j < last; j++) sum = sum + int'(model_lfsr(j));
        return sum[15:0];
    endfunction

    function automatic logic [1:0] model_state(input int k);
        if (k == 0)  return 2'd0;
        if (k <= 16) return 2'd1;
        return 2'd2;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_count",     32'(count),     32'(n % 256));
            chk("model_lfsr",      32'(lfsr),      32'(model_lfsr(n)));
            chk("model_heartbeat", 32'(heartbeat), 32'((n / 4) % 2));
            chk("model_state",     32'(state),     32'(model_state(n)));
            chk("model_checksum",  32'(checksum),  32'(model_checksum(n)));
            chk("model_done",      32'(done),      32'(model_state(n) == 2'd2));
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},     32'(count),     32'h0);
        chk({tag, "_lfsr"},      32'(lfsr),      32'hACE1);
        chk({tag, "_state"},     32'(state),     32'h0);
        chk({tag, "_checksum"},  32'(checksum),  32'h0);
        chk({tag, "_done"},      32'(done),      32'h0);
        chk({tag, "_heartbeat"}, 32'(heartbeat), 32'h0);
    endtask

    task automatic edge_then_sample(input int k);
        repeat (k) @(posedge clk);
        #5;
    endtask

    initial begin
        reset = 1'b1;
        #15 check_en = 1'b1;
        #135;                               // t = 150, still in reset
        check_reset_values("reset");
        $display("txn reset values at %0t", $time);
        #50 reset = 1'b0;                   // release at 200 ns

        edge_then_sample(1);                // E1
        chk("e1_state", 32'(state), 32'h1);
        chk("e1_count", 32'(count), 32'h1);
        chk("e1_lfsr",  32'(lfsr),  32'h59C3);
        $display("txn E1 state=%0d count=%0h lfsr=%h", state, count, lfsr);
        edge_then_sample(1);                // E2
        chk("e2_lfsr",     32'(lfsr),     32'hB387);
        chk("e2_checksum", 32'(checksum), 32'h59C3);
        $display("txn E2 lfsr=%h checksum=%h", lfsr, checksum);
        edge_then_sample(1);                // E3
        chk("e3_checksum", 32'(checksum), 32'h0D4A);
        $display("txn E3 checksum=%h", checksum);
        edge_then_sample(1);                // E4
        chk("e4_heartbeat", 32'(heartbeat), 32'h1);
        edge_then_sample(3);                // E7
        chk("e7_heartbeat", 32'(heartbeat), 32'h1);
        edge_then_sample(1);                // E8
        chk("e8_heartbeat", 32'(heartbeat), 32'h0);
        $display("txn heartbeat edges E4/E8 ok-checked");
        edge_then_sample(8);                // E16
        chk("e16_state", 32'(state), 32'h1);
        chk("e16_done",  32'(done),  32'h0);
        edge_then_sample(1);                // E17
        chk("e17_state", 32'(state), 32'h2);
        chk("e17_done",  32'(done),  32'h1);
        $display("txn E17 state=%0d done=%0b checksum=%h", state, done, checksum);

        edge_then_sample(255 - 17);         // E255
        chk("wrap_ff", 32'(count), 32'hFF);
        edge_then_sample(1);                // E256
        chk("wrap_00", 32'(count), 32'h00);
        chk("wrap_done_sticky", 32'(state), 32'h2);
        $display("txn count wrap %h", count);

        // Reset from DONE, then a short pulse in the middle of RUN.
        @(posedge clk); #3 reset = 1'b1;
        #2 check_reset_values("rst_done");
        #3 reset = 1'b0;
        edge_then_sample(3);                // E3 of second run
        chk("run2_state", 32'(state), 32'h1);
        @(posedge clk); #3 reset = 1'b1;
        #2 check_reset_values("pulse");
        $display("txn reset pulse in RUN at %0t", $time);
        #3 reset = 1'b0;
        edge_then_sample(1);
        chk("pulse_e1_state", 32'(state), 32'h1);
        chk("pulse_e1_lfsr",  32'(lfsr),  32'h59C3);
        edge_then_sample(1);
        chk("pulse_e2_lfsr",     32'(lfsr),     32'hB387);
        chk("pulse_e2_checksum", 32'(checksum), 32'h59C3);
        $display("txn restart lfsr=%h checksum=%h", lfsr, checksum);
        edge_then_sample(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
